register_dump_unit: RTL and testbench
=====================================

REGISTER_DUMP_UNIT -- requirements
Module: register_dump_unit

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: number of registers dumped, addresses 0..NUM_REGS-1.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: width of the register-read address.
REQ-003 SHALL have port i_clk, input, 1: clock; all state changes on the rising edge.
REQ-004 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_start, input, 1: dump request, sampled only in IDLE.
REQ-006 SHALL have port o_halt, output, 1: freezes the pipeline and hands the register-bank read port to this block.
REQ-007 SHALL have port o_reg_read, output, ADDR_WIDTH: register address driven to the decode-stage debug read port.
REQ-008 SHALL have port i_reg_content, input, 32: register contents returned combinationally for o_reg_read.
REQ-009 SHALL have port o_tx_data, output, 8: byte toward the serial transmitter.
REQ-010 SHALL have port o_tx_valid, output, 1: o_tx_data is valid.
REQ-011 SHALL have port i_tx_ready, input, 1: transmitter accepts the byte.
REQ-012 SHALL have port o_busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port o_done, output, 1: one-cycle pulse when the dump completes.

Function
REQ-014 SHALL implement the states IDLE, SELECT, SEND and DONE.
REQ-015 In IDLE with i_start=1, SHALL clear the index to 0, set o_halt=1 and enter SELECT.
REQ-016 In IDLE with i_start=0, SHALL remain in IDLE.
REQ-017 SHALL drive o_reg_read from the registered index at all times.
REQ-018 SELECT SHALL last exactly one cycle; at the exit edge it SHALL latch i_reg_content into a 32-bit shift register, clear the byte count and enter SEND.
REQ-019 In SEND, o_tx_valid SHALL be 1 and o_tx_data SHALL equal shift register bits [31:24], so bytes go out MSB first.
REQ-020 A handshake SHALL occur on a cycle with o_tx_valid=1 and i_tx_ready=1.
REQ-021 On each handshake, the block SHALL shift the register left by 8 bits and increment the byte count (2 bits).
REQ-022 While o_tx_valid=1 and i_tx_ready=0, o_tx_data SHALL stay stable and o_tx_valid SHALL not drop.
REQ-023 On the handshake of byte 3 with index < NUM_REGS-1, SHALL increment the index and enter SELECT.
REQ-024 On the handshake of byte 3 with index = NUM_REGS-1, SHALL enter DONE.
REQ-025 In DONE, o_done SHALL be 1 for that single cycle; the next edge SHALL return to IDLE with o_halt=0 and index=0.
REQ-026 o_halt SHALL be 1 in SELECT, SEND and DONE, and 0 in IDLE.
REQ-027 o_tx_valid SHALL be 0 outside SEND.
REQ-028 i_start SHALL be ignored outside IDLE; a dump is never restarted or extended.
REQ-029 The index SHALL never wrap; the maximum value reached is NUM_REGS-1.
REQ-030 Latency with i_tx_ready held at 1: start sampled at edge E0 -> first o_tx_valid after E1 -> o_done high after E(5*NUM_REGS) -> IDLE after E(5*NUM_REGS+1).
REQ-031 Total output SHALL be exactly 4*NUM_REGS bytes per dump, in register order 0..NUM_REGS-1.

Reset
REQ-032 On i_reset=1 at an edge, the block SHALL enter IDLE with o_halt=0, o_reg_read=0, o_tx_data=0, o_tx_valid=0, o_busy=0 and o_done=0.
REQ-033 On reset, the shift register and byte count SHALL be cleared.
REQ-034 Reset SHALL take priority over i_start in the same cycle; no dump starts.
REQ-035 Reset mid-dump SHALL abort the dump: o_tx_valid=0 and o_halt=0 after that edge, no o_done pulse, and no further bytes.

Verification
REQ-036 Bench SHALL cover: bank model with reg[n]=n*0x01010101, i_tx_ready=1, start pulse -> 128 bytes 00 00 00 00, 01 01 01 01, ..., 1F 1F 1F 1F; o_done exactly at E160.
REQ-037 Bench SHALL cover: reg1=0xDEADBEEF -> bytes 4..7 are DE AD BE EF; o_reg_read=1 during those SEND cycles.
REQ-038 Bench SHALL cover: i_tx_ready random at 50% -> same byte sequence as the ready=1 case; o_tx_data/o_tx_valid stable in every stalled cycle; o_halt high throughout.
REQ-039 Bench SHALL cover: i_start re-pulsed during SEND of reg 5 -> no effect; byte count still 128; single o_done pulse.
REQ-040 Bench SHALL cover: i_reset asserted during byte 2 of reg 10 -> next cycle o_tx_valid=0, o_halt=0, o_busy=0; a following start dumps from reg 0.
REQ-041 Bench SHALL cover: i_reset and i_start high in the same cycle -> stays in IDLE, o_halt=0.

Source files
------------

// File: rtl/register_dump_unit.sv
// register_dump_unit: halts the core and streams every register out MSB-first as bytes over a valid/ready link
module register_dump_unit #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic                  o_halt,
    output logic [ADDR_WIDTH-1:0] o_reg_read,
    input  logic [31:0]           i_reg_content,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);
    typedef enum logic [1:0] {IDLE, SELECT, SEND, DONE} state_t;
    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_index, w_index;
    logic [31:0]           r_shift, w_shift;
    logic [1:0]            r_count, w_count;
    logic                  w_last;
    assign w_last = r_index == ADDR_WIDTH'(NUM_REGS - 1);
    always_comb begin
        w_next  = r_state;
        w_index = r_index;
        w_shift = r_shift;
        w_count = r_count;
        case (r_state)
            IDLE: if (i_start) begin
                w_next  = SELECT;
                w_index = '0;
            end
            SELECT: begin
                w_shift = i_reg_content;
                w_count = '0;
                w_next  = SEND;
            end
            SEND: if (i_tx_ready) begin
                w_shift = {r_shift[23:0], 8'h00};
                w_count = r_count + 2'd1;
                if (r_count == 2'd3) begin
                    w_next  = w_last ? DONE : SELECT;
                    w_index = w_last ? r_index : r_index + 1'b1;
                end
            end
            DONE: begin
                w_next  = IDLE;
                w_index = '0;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_index <= '0;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_index <= w_index;
            r_shift <= w_shift;
            r_count <= w_count;
        end
    end
    assign o_halt     = r_state != IDLE;
    assign o_busy     = r_state != IDLE;
    assign o_reg_read = r_index;
    assign o_tx_valid = r_state == SEND;
    // the shift register is zero outside a latched word, so the data bus idles at 0
    assign o_tx_data  = r_shift[31:24];
    assign o_done     = r_state == DONE;
endmodule

// File: tb/tb_register_dump_unit.sv
// tb_register_dump_unit: vector table for reset/start/stall corners plus modelled full dumps
module tb_register_dump_unit;
    localparam int N = 32;
    logic       clk = 0, i_reset = 0, i_start = 0, i_tx_ready = 0;
    logic       o_halt, o_tx_valid, o_busy, o_done;
    logic [4:0] o_reg_read;
    logic [7:0] o_tx_data;
    logic [31:0] bank [N];
    logic [31:0] w_content;
    int n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;
    assign w_content = bank[o_reg_read];
    register_dump_unit #(.NUM_REGS(N), .ADDR_WIDTH(5)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .o_halt(o_halt),
        .o_reg_read(o_reg_read), .i_reg_content(w_content), .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_busy(o_busy), .o_done(o_done)
    );
    typedef struct {
        logic rst, start, ready;
        logic busy, halt, valid, done;
        logic [4:0] rr;
        logic [7:0] data;
    } vec_t;
    vec_t tv [17];
    function automatic vec_t v(logic rs, logic st, logic rd, logic bs, logic hl, logic vl, logic dn,
                               logic [4:0] rr, logic [7:0] d);
        vec_t x;
        x.rst = rs; x.start = st; x.ready = rd; x.busy = bs; x.halt = hl;
        x.valid = vl; x.done = dn; x.rr = rr; x.data = d;
        return x;
    endfunction
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic dump(input int pct, input int restart_at, input int abort_at);
        logic [7:0] exp_q [$];
        logic [7:0] got_q [$];
        logic [7:0] pd;
        int k, dones, bad;
        bit pv, pr, rst_now, restarted, finished;
        for (int r = 0; r < N; r++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(bank[r][8*b +: 8]);
        i_start = 1; i_tx_ready = 0;
        step();
        i_start = 0;
        k = 0; dones = 0; restarted = 0; finished = 0;
        check("start_halt", o_halt, 1);
        while (!finished && k < 20000) begin
            i_tx_ready = $urandom_range(99) < pct;
            i_start = restart_at >= 0 && !restarted && o_tx_valid && got_q.size() == restart_at;
            if (i_start) restarted = 1;
            i_reset = abort_at >= 0 && o_tx_valid && got_q.size() == abort_at;
            if (i_reset) i_tx_ready = 0;
            if (o_tx_valid) check("reg_read", 32'(o_reg_read), 32'(got_q.size() / 4));
            if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
            pv = o_tx_valid; pr = i_tx_ready; pd = o_tx_data; rst_now = i_reset;
            step();
            k++;
            i_start = 0;
            if (rst_now) begin
                i_reset = 0;
                check("abort_valid", o_tx_valid, 0);
                check("abort_halt", o_halt, 0);
                check("abort_busy", o_busy, 0);
                finished = 1;
            end else begin
                if (pv && !pr) begin
                    check("stall_valid", o_tx_valid, 1);
                    check("stall_data", o_tx_data, pd);
                end
                if (o_done) begin
                    dones++;
                    if (pct == 100) check("done_cycle", k, 5 * N);
                end else if (dones > 0) begin
                    check("end_halt", o_halt, 0);
                    check("end_busy", o_busy, 0);
                    finished = 1;
                end else check("halt_high", o_halt, 1);
            end
        end
        if (!finished) check("timeout", 0, 1);
        if (abort_at >= 0) begin
            check("abort_bytes", got_q.size(), abort_at);
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                if (o_done || o_tx_valid || o_halt) bad++;
                step();
            end
            check("abort_quiet", bad, 0);
        end else begin
            check("byte_count", got_q.size(), 4 * N);
            check("done_pulses", dones, 1);
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        end
    endtask
    initial begin
        for (int n = 0; n < N; n++) bank[n] = n * 32'h01010101;
        bank[1] = 32'hDEADBEEF;
        tv[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tv[1]  = v(1, 1, 0, 0, 0, 0, 0, 0, 8'h00);
        tv[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tv[3]  = v(0, 1, 1, 1, 1, 0, 0, 0, 8'h00);
        tv[4]  = v(0, 0, 1, 1, 1, 1, 0, 0, 8'h00);
        tv[5]  = v(0, 0, 1, 1, 1, 1, 0, 0, 8'h00);
        tv[6]  = v(0, 0, 1, 1, 1, 1, 0, 0, 8'h00);
        tv[7]  = v(0, 0, 1, 1, 1, 1, 0, 0, 8'h00);
        tv[8]  = v(0, 0, 1, 1, 1, 0, 0, 1, 8'h00);
        tv[9]  = v(0, 0, 1, 1, 1, 1, 0, 1, 8'hDE);
        tv[10] = v(0, 0, 0, 1, 1, 1, 0, 1, 8'hDE);
        tv[11] = v(0, 0, 1, 1, 1, 1, 0, 1, 8'hAD);
        tv[12] = v(0, 0, 1, 1, 1, 1, 0, 1, 8'hBE);
        tv[13] = v(0, 0, 1, 1, 1, 1, 0, 1, 8'hEF);
        tv[14] = v(0, 0, 1, 1, 1, 0, 0, 2, 8'h00);
        tv[15] = v(0, 1, 1, 1, 1, 1, 0, 2, 8'h02);
        tv[16] = v(1, 0, 1, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 17; i++) begin
            i_reset = tv[i].rst; i_start = tv[i].start; i_tx_ready = tv[i].ready;
            step();
            check($sformatf("v%0d_busy", i), o_busy, tv[i].busy);
            check($sformatf("v%0d_halt", i), o_halt, tv[i].halt);
            check($sformatf("v%0d_valid", i), o_tx_valid, tv[i].valid);
            check($sformatf("v%0d_done", i), o_done, tv[i].done);
            check($sformatf("v%0d_rr", i), o_reg_read, tv[i].rr);
            check($sformatf("v%0d_data", i), o_tx_data, tv[i].data);
        end
        i_reset = 0; i_start = 0;
        step();
        bank[1] = 32'h01010101;
        dump(100, -1, -1);
        bank[1] = 32'hDEADBEEF;
        dump(100, -1, -1);
        for (int n = 0; n < N; n++) bank[n] = $urandom;
        dump(50, -1, -1);
        dump(50, 21, -1);
        dump(100, -1, 42);
        dump(100, -1, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
